// File: rtl/fir_tap_sequencer.sv
// Sample-history controller: shifts accepted ADC samples into an M-deep history and
// streams every entry with its tap index. Optional drop counter: FIR_SEQ_OVERRUN_CNT_EN.
module fir_tap_sequencer #(
    parameter int M  = 6,
    parameter int W  = 12,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          flush,
    input  logic [W-1:0]  sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    output logic [W-1:0]  tap_sample,
    output logic [IW-1:0] tap_idx,
    output logic          tap_valid,
    input  logic          tap_ready,
    output logic          tap_first,
    output logic          tap_last,
    output logic          done,
    output logic [15:0]   ovr_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid/ready never depend combinationally on the partner's signal.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    state_t        state, state_next;
    logic [IW-1:0] idx;
    logic [W-1:0]  hist [M];
    logic          accept, tap_fire, drop;

    assign accept   = en && (state == IDLE) && sample_valid && !flush;
    assign tap_fire = en && (state == RUN) && tap_ready && !flush;
    assign drop     = en && sample_valid && !sample_ready && !flush;

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (sample_valid) state_next = RUN;
                RUN:     if (tap_ready && idx == LAST_IDX) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < M; i++) hist[i] <= '0;
        end else if (en) begin
            state <= state_next;
            if (flush) begin
                idx <= '0;
                for (int i = 0; i < M; i++) hist[i] <= '0;
            end else if (accept) begin
                for (int i = M - 1; i > 0; i--) hist[i] <= hist[i-1];
                hist[0] <= sample_in;
                idx     <= '0;
            end else if (tap_fire && idx != LAST_IDX) begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Outputs decode registered state only; tap data is zero outside a run.
    always_comb begin
        sample_ready = en && (state == IDLE);
        tap_valid    = en && (state == RUN);
        done         = en && (state == DONE);
        tap_sample   = '0;
        tap_idx      = '0;
        if (state == RUN) begin
            tap_sample = hist[idx];
            tap_idx    = idx;
        end
        tap_first = tap_valid && (idx == '0);
        tap_last  = tap_valid && (idx == LAST_IDX);
    end

`ifdef FIR_SEQ_OVERRUN_CNT_EN
    logic [15:0] ovr_q;

    // Saturating; flush deliberately leaves it alone so drops stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else if (drop && ovr_q != 16'hFFFF) begin
            ovr_q <= ovr_q + 16'd1;
        end
    end

    assign ovr_cnt = ovr_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign ovr_cnt     = '0;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: reference model checked every falling edge, tap data
// checked against an expected queue filled at sample acceptance.
module tb_fir_tap_sequencer;

    localparam int M  = 6;
    localparam int W  = 12;
    localparam int IW = 3;
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    localparam int OVR_EN = 1;
`else
    localparam int OVR_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, en, flush, sample_valid, tap_ready;
    logic [W-1:0]  sample_in;
    logic          sample_ready, tap_valid, tap_first, tap_last, done;
    logic [W-1:0]  tap_sample;
    logic [IW-1:0] tap_idx;
    logic [15:0]   ovr_cnt;

    fir_tap_sequencer #(.M(M), .W(W), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .tap_sample(tap_sample), .tap_idx(tap_idx), .tap_valid(tap_valid),
        .tap_ready(tap_ready), .tap_first(tap_first), .tap_last(tap_last),
        .done(done), .ovr_cnt(ovr_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    logic [IW+W-1:0] exp_q[$];
    logic [W-1:0]    m_hist [M];
    int              m_st;      // 0 idle, 1 run, 2 done
    logic [15:0]     m_ovr;
    logic [IW+W-1:0] head;
    logic            m_ready, m_tv;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_st  = 0;
            m_ovr = '0;
            for (int i = 0; i < M; i++) m_hist[i] = '0;
            exp_q.delete();
        end else begin
            m_ready = en && (m_st == 0);
            m_tv    = en && (m_st == 1);
            head    = (exp_q.size() != 0) ? exp_q[0] : '0;
            check("sample_ready", sample_ready, m_ready);
            check("tap_valid", tap_valid, m_tv);
            check("done", done, en && (m_st == 2));
            check("ovr_cnt", ovr_cnt, m_ovr);
            check("tap_first", tap_first, m_tv && (head[IW+W-1:W] == 0));
            check("tap_last", tap_last, m_tv && (head[IW+W-1:W] == IW'(M - 1)));
            if (m_tv) begin
                check("tap_q_nonempty", exp_q.size() != 0, 1);
                check("tap_sample", tap_sample, head[W-1:0]);
                check("tap_idx", tap_idx, head[IW+W-1:W]);
            end
            if (en) begin
                if (OVR_EN != 0 && sample_valid && !m_ready && !flush && m_ovr != 16'hFFFF)
                    m_ovr = m_ovr + 16'd1;
                if (flush) begin
                    for (int i = 0; i < M; i++) m_hist[i] = '0;
                    exp_q.delete();
                    m_st = 0;
                end else if (m_st == 0) begin
                    if (sample_valid) begin
                        for (int i = M - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                        m_hist[0] = sample_in;
                        for (int i = 0; i < M; i++) exp_q.push_back({IW'(i), m_hist[i]});
                        m_st = 1;
                    end
                end else if (m_st == 1) begin
                    if (tap_ready && exp_q.size() != 0) begin
                        head = exp_q.pop_front();
                        if (head[IW+W-1:W] == IW'(M - 1)) m_st = 2;
                    end
                end else begin
                    m_st = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [W-1:0] v);
        int n = 0;
        sample_valid = 1'b1;
        sample_in    = v;
        while (!sample_ready && n < 60) begin
            tick();
            n++;
        end
        check("accept_timeout", n < 60, 1);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!sample_ready && n < 60) begin
            tick();
            n++;
        end
        check("idle_timeout", n < 60, 1);
    endtask

    task automatic wait_tap(input int i);
        int n = 0;
        while (!(tap_valid && tap_idx == IW'(i)) && n < 60) begin
            tick();
            n++;
        end
        check("tap_wait_timeout", n < 60, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int          n;
    logic [15:0] ovr0;
    logic [W-1:0] held;

    initial begin
        rst_n = 1'b0; en = 1'b1; flush = 1'b0;
        sample_valid = 1'b0; sample_in = '0; tap_ready = 1'b1;
        #3;
        check("rst_sample_ready", sample_ready, 1);
        check("rst_tap_valid", tap_valid, 0);
        check("rst_tap_sample", tap_sample, 0);
        check("rst_done", done, 0);
        check("rst_ovr", ovr_cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Samples 1..6, then timing of the last run.
        for (int v = 1; v <= 5; v++) begin
            send_sample(W'(v));
            wait_idle();
        end
        send_sample(W'(6));
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("done_latency", n, M);
        tick();
        check("ready_after_done", sample_ready, 1);

        // Stall at idx 2.
        send_sample(W'(7));
        wait_tap(2);
        tap_ready = 1'b0;
        held = tap_sample;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_idx", tap_idx, 2);
            check("stall_sample", tap_sample, held);
        end
        tap_ready = 1'b1;
        wait_idle();

        // Overrun: valid held through a whole run.
        ovr0 = ovr_cnt;
        sample_valid = 1'b1;
        sample_in    = W'(8);
        tick();
        n = 0;
        while (!sample_ready && n < 20) begin
            tick();
            n++;
        end
        sample_valid = 1'b0;
        check("ovr_delta", ovr_cnt - ovr0, (OVR_EN != 0) ? 7 : 0);

        // Flush at idx 3, then 0xABC streams against a cleared history.
        send_sample(W'(9));
        wait_tap(3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", sample_ready, 1);
        send_sample(W'(12'hABC));
        wait_idle();

        // Enable dropped for 4 cycles mid-run.
        send_sample(W'(10));
        wait_tap(2);
        en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("en_low_tv", tap_valid, 0);
        end
        en = 1'b1;
        #1;
        check("en_resume_idx", tap_idx, 2);
        wait_idle();

        // Asynchronous reset between edges.
        send_sample(W'(11));
        wait_tap(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tap_valid", tap_valid, 0);
        check("arst_tap_sample", tap_sample, 0);
        check("arst_tap_idx", tap_idx, 0);
        check("arst_ready", sample_ready, 1);
        check("arst_ovr", ovr_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_sample(W'(12));
        wait_idle();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            sample_valid = ($urandom_range(0, 2) != 0);
            sample_in    = W'($urandom_range(0, 4095));
            tap_ready    = ($urandom_range(0, 3) != 0);
            en           = ($urandom_range(0, 9) != 0);
            flush        = ($urandom_range(0, 29) == 0);
            tick();
        end
        sample_valid = 1'b0; flush = 1'b0; en = 1'b1; tap_ready = 1'b1;
        wait_idle();
        tick();
        check("final_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Controller for the filter sample-history buffer. Accepts one 12-bit ADC sample per handshake and shifts it into an M-deep history (entry 0 newest). It then streams every history entry, with its tap index, to the downstream coefficient-multiply/accumulate stage, one tap per cycle under valid/ready flow control. It sits between the ADC capture front end and the filter MAC, and owns the history register file.

## Interface
- M, 6: history depth / number of taps (2..16).
- W, 12: sample width.
- IW, 3: tap index width; must satisfy 2^IW >= M.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; low freezes all state.
- flush  in  1  synchronous clear of history; aborts any run.
- sample_in  in  W  new ADC sample.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  sequencer can accept a sample.
- tap_sample  out  W  history entry for current tap.
- tap_idx  out  IW  current tap index (coefficient address).
- tap_valid  out  1  tap_sample/tap_idx valid.
- tap_ready  in  1  downstream consumes current tap.
- tap_first  out  1  high with tap_idx==0.
- tap_last  out  1  high with tap_idx==M-1.
- done  out  1  one-cycle pulse after last tap consumed.
- ovr_cnt  out  16  dropped-sample counter (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - sample_ready = en.
  - On sample_valid && sample_ready: hist[i] <= hist[i-1] for i = 1..M-1, hist[0] <= sample_in, idx <= 0, go to RUN.
- RUN:
  - tap_valid = en; tap_sample = hist[idx]; tap_idx = idx.
  - On tap_valid && tap_ready: if idx == M-1, go to DONE; else idx <= idx+1.
  - Without tap_ready, idx and all tap outputs hold.
- DONE: done = 1 for exactly one cycle; go to IDLE.
- en low: no state, idx, history or counter update; sample_ready, tap_valid and done forced 0. Operation resumes in the same state when en returns high.
- flush high (with en high), any state:
  - All hist entries <= 0; idx <= 0; go to IDLE.
  - No done pulse.
  - flush takes priority over a simultaneous sample or tap handshake; that sample is not stored and not counted as dropped.
  - flush with en low is ignored.
- Dropped sample: en && sample_valid && !sample_ready && !flush, evaluated each cycle.
- History is not modified during RUN or DONE; taps always reflect the snapshot taken at acceptance.

## Timing
- Reset (rst_n low, asynchronous):
  - state IDLE, idx 0, all hist 0, ovr_cnt 0.
  - Outputs: sample_ready = en, tap_valid 0, tap_first 0, tap_last 0, done 0, tap_sample 0, tap_idx 0.
- Reset mid-run discards the run; no done pulse is produced.
- All outputs are decoded combinationally from registered state; sample_in→tap_sample has no combinational path.
- With tap_ready held high, for a sample accepted at edge k:
  - taps 0..M-1 valid in cycles k+1..k+M;
  - done high in cycle k+M+1;
  - sample_ready high again in cycle k+M+2.
- Throughput: one sample per M+2 cycles.
- Each cycle tap_ready is low adds exactly one cycle of latency.
- tap_first and tap_last are gated by tap_valid.
- For M == 1, not allowed: minimum M is 2.

## Configuration
- FIR_SEQ_OVERRUN_CNT_EN:
  - Defined: ovr_cnt increments on each dropped sample and saturates at 16'hFFFF. Cleared by reset only, not by flush.
  - Undefined: counter logic is not compiled; ovr_cnt is tied to 0.

## Test plan
- Reset, then accept samples 1..6 with tap_ready high. After the 6th, taps stream values 6,5,4,3,2,1 at idx 0..5. tap_first is high only on idx 0, tap_last only on idx 5. done pulses at k+7; sample_ready returns at k+8.
- Hold tap_ready low for 3 cycles at idx 2: tap_idx stays 2 and tap_sample is stable. Sequence completes 3 cycles later; done fires once.
- Keep sample_valid high throughout a run with the macro defined: ovr_cnt increases by 7 per run (M+1 blocked cycles). With the macro undefined, ovr_cnt stays 0.
- Assert flush at idx 3: next cycle state is IDLE, no done pulse. The next accepted sample 0xABC streams as 0xABC,0,0,0,0,0.
- Drop en for 4 cycles mid-run: tap_valid is 0 and idx is frozen for those cycles. Sequence resumes at the same idx.
- Assert rst_n low asynchronously mid-run (between edges): all outputs take reset values immediately and history reads all zeros afterwards.
